// File: rtl/i2s_dac_tx.sv
// i2s_dac_tx: one-entry sample buffer feeding a free-running I2S transmitter.
// The same mono sample is sent in the left and the right slot of each frame.
// BCLK and LRCLK are divided down from CLK. If a frame starts with no fresh
// sample, the previous sample is sent again and underrun pulses for one cycle.
module i2s_dac_tx #(
  parameter int DATA_WIDTH = 32,
  parameter int SLOT_WIDTH = 32,
  parameter int BCLK_DIV   = 4
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic                  mute,
  output logic                  bclk,
  output logic                  lrclk,
  output logic                  sdata,
  output logic                  underrun
);

  localparam int FRAME  = 2 * SLOT_WIDTH;
  localparam int DIV_W  = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
  localparam int BIT_W  = $clog2(FRAME);

  logic [DIV_W-1:0]      div_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [BIT_W-1:0]      bit_nxt;
  logic [BIT_W-1:0]      slot_idx;
  logic [DATA_WIDTH-1:0] buf_q;
  logic [DATA_WIDTH-1:0] last_sample;
  logic [SLOT_WIDTH-1:0] buf_word;
  logic [SLOT_WIDTH-1:0] last_word;
  logic [SLOT_WIDTH-1:0] shreg;
  logic [SLOT_WIDTH-1:0] frame_word;
  logic [SLOT_WIDTH-1:0] word_src;
  logic [SLOT_WIDTH-1:0] word_sel;
  logic                  buf_full;
  logic                  div_tc;
  logic                  fall_ev;
  logic                  frame_start;
  logic                  xfer;
  logic                  consume;

  // Fit a sample into one slot word: keep the MSBs when the sample is wider
  // than the slot, left-justify with zero LSBs when it is narrower.
  generate
    if (DATA_WIDTH >= SLOT_WIDTH) begin : g_trunc
      assign buf_word  = buf_q[DATA_WIDTH-1 -: SLOT_WIDTH];
      assign last_word = last_sample[DATA_WIDTH-1 -: SLOT_WIDTH];
    end else begin : g_pad
      assign buf_word  = {buf_q, {(SLOT_WIDTH-DATA_WIDTH){1'b0}}};
      assign last_word = {last_sample, {(SLOT_WIDTH-DATA_WIDTH){1'b0}}};
    end
  endgenerate

  assign din_ready   = ~buf_full;
  assign xfer        = din_valid & ~buf_full;
  assign div_tc      = (div_cnt == DIV_W'(BCLK_DIV - 1));
  // Every data/word-select change happens on the CLK edge that drops bclk.
  assign fall_ev     = div_tc & bclk;
  assign bit_nxt     = (bit_cnt == BIT_W'(FRAME - 1)) ? '0 : bit_cnt + 1'b1;
  assign frame_start = fall_ev & (bit_cnt == BIT_W'(FRAME - 1));
  // A frame start only drains the buffer when it is not muted.
  assign consume     = frame_start & ~mute & buf_full;

  // Word for the frame that is starting; the buffer is sampled before any
  // same-edge transfer, so a simultaneous handshake counts as an underrun.
  assign frame_word  = mute     ? '0       :
                       buf_full ? buf_word : last_word;
  assign word_src    = frame_start ? frame_word : shreg;
  // Right slot repeats the left slot, so fold the bit index into one slot.
  assign slot_idx    = (bit_nxt >= BIT_W'(SLOT_WIDTH)) ? bit_nxt - BIT_W'(SLOT_WIDTH)
                                                       : bit_nxt;
  assign word_sel    = word_src << slot_idx;

  // Free-running BCLK divider.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (div_tc) begin
      div_cnt <= '0;
      bclk    <= ~bclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Bit position within the frame, LRCLK one BCLK ahead of the slot, serial data.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      bit_cnt <= BIT_W'(FRAME - 1);
      lrclk   <= 1'b0;
      sdata   <= 1'b0;
    end else if (fall_ev) begin
      bit_cnt <= bit_nxt;
      sdata   <= word_sel[SLOT_WIDTH-1];
      if (bit_nxt == BIT_W'(SLOT_WIDTH - 1))
        lrclk <= 1'b1;
      else if (bit_nxt == BIT_W'(FRAME - 1))
        lrclk <= 1'b0;
    end
  end

  // Frame word latch, repeat-sample history and underrun flag.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      shreg       <= '0;
      last_sample <= '0;
      underrun    <= 1'b0;
    end else begin
      underrun <= frame_start & ~mute & ~buf_full;
      if (frame_start)
        shreg <= frame_word;
      if (consume)
        last_sample <= buf_q;
    end
  end

  // One-entry input buffer; drained at a non-muted frame start.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      buf_q    <= '0;
      buf_full <= 1'b0;
    end else if (consume) begin
      buf_full <= 1'b0;
    end else if (xfer) begin
      buf_q    <= din;
      buf_full <= 1'b1;
    end
  end

endmodule
